// File: rtl/urv_defs.sv
// Shared uRV definitions: 5-bit major opcodes (ir[6:2]) and the funct7 encodings
// that the decode stage accepts for OP instructions.
package urv_defs;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/urv_decode_imm.sv
// Combinational immediate generator: picks the I/S/B/U/J layout from the opcode
// and sign-extends from ir[31]; opcodes without an immediate yield 0.
module urv_decode_imm
  import urv_defs::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (ir[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
        imm = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {ir[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/urv_decode_stage.sv
// uRV decode stage: registers the fetched word, decodes fields/flags and inserts a
// one-cycle bubble on load-use hazards. Optional M-extension decode: URV_DECODE_MUL_EN.
module urv_decode_stage
  import urv_defs::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  output logic        d_stall_o,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  output logic        d_valid_o,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_ir_o,
  output logic [4:0]  d_opcode_o,
  output logic [2:0]  d_fun_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [4:0]  d_rd_o,
  output logic [31:0] d_imm_o,
  output logic        d_is_load_o,
  output logic        d_is_store_o,
  output logic        d_is_branch_o,
  output logic        d_is_mul_o,
  output logic        d_illegal_o
);

  logic [4:0]  f_opcode;
  logic [6:0]  f_funct7;
  logic [31:0] f_imm;
  logic        f_is_mul;
  logic        f_illegal;
  logic        f_uses_rs1;
  logic        f_uses_rs2;
  logic        hazard;

  assign f_opcode = f_ir_i[6:2];
  assign f_funct7 = f_ir_i[31:25];

  urv_decode_imm u_imm (
    .ir  (f_ir_i),
    .imm (f_imm)
  );

  always_comb begin
    f_is_mul  = 1'b0;
    f_illegal = 1'b0;
    if (f_ir_i[1:0] != 2'b11)
      f_illegal = 1'b1;
    if (!(f_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                           OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM, OPC_MISC_MEM}))
      f_illegal = 1'b1;
    if (f_opcode == OPC_OP) begin
`ifdef URV_DECODE_MUL_EN
      if (f_funct7 == F7_MULDIV)
        f_is_mul = 1'b1;
      else if (f_funct7 != F7_BASE && f_funct7 != F7_ALT)
        f_illegal = 1'b1;
`else
      if (f_funct7 != F7_BASE && f_funct7 != F7_ALT)
        f_illegal = 1'b1;
`endif
    end
  end

  // Load-use check compares the incoming word's sources against the held load's rd.
  assign f_uses_rs1 = !(f_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign f_uses_rs2 = f_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  assign hazard = f_valid_i & d_valid_o & d_is_load_o & (d_rd_o != 5'd0) &
                  ((f_uses_rs1 & (f_ir_i[19:15] == d_rd_o)) |
                   (f_uses_rs2 & (f_ir_i[24:20] == d_rd_o)));

  assign d_stall_o = x_stall_i | (hazard & !x_kill_i);

  assign d_opcode_o = d_ir_o[6:2];
  assign d_fun_o    = d_ir_o[14:12];
  assign d_rs1_o    = d_ir_o[19:15];
  assign d_rs2_o    = d_ir_o[24:20];
  assign d_rd_o     = d_ir_o[11:7];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_valid_o     <= 1'b0;
      d_pc_o        <= '0;
      d_ir_o        <= '0;
      d_imm_o       <= '0;
      d_is_load_o   <= 1'b0;
      d_is_store_o  <= 1'b0;
      d_is_branch_o <= 1'b0;
      d_is_mul_o    <= 1'b0;
      d_illegal_o   <= 1'b0;
    end else if (x_kill_i) begin
      d_valid_o <= 1'b0;
    end else if (x_stall_i) begin
      d_valid_o <= d_valid_o;
    end else if (hazard) begin
      d_valid_o <= 1'b0;
    end else begin
      d_valid_o     <= f_valid_i;
      d_pc_o        <= f_pc_i;
      d_ir_o        <= f_ir_i;
      d_imm_o       <= f_imm;
      d_is_load_o   <= (f_opcode == OPC_LOAD);
      d_is_store_o  <= (f_opcode == OPC_STORE);
      d_is_branch_o <= (f_opcode == OPC_BRANCH);
      d_is_mul_o    <= f_is_mul;
      d_illegal_o   <= f_illegal;
    end
  end

endmodule

// File: tb/tb_urv_decode_stage.sv
// Scoreboard bench for urv_decode_stage: a behavioural pipeline-slot model predicts
// per-cycle valid/stall and decoded fields; a negedge monitor pops and compares.
module tb_urv_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        f_valid_i = 1'b0;
  logic [31:0] f_ir_i = '0;
  logic [31:0] f_pc_i = '0;
  logic        x_stall_i = 1'b0;
  logic        x_kill_i = 1'b0;
  logic        d_stall_o, d_valid_o;
  logic [31:0] d_pc_o, d_ir_o, d_imm_o;
  logic [4:0]  d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
  logic [2:0]  d_fun_o;
  logic        d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o;

  urv_decode_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .f_valid_i(f_valid_i), .f_ir_i(f_ir_i),
    .f_pc_i(f_pc_i), .d_stall_o(d_stall_o), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_ir_o(d_ir_o), .d_opcode_o(d_opcode_o),
    .d_fun_o(d_fun_o), .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o),
    .d_imm_o(d_imm_o), .d_is_load_o(d_is_load_o), .d_is_store_o(d_is_store_o),
    .d_is_branch_o(d_is_branch_o), .d_is_mul_o(d_is_mul_o), .d_illegal_o(d_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm;
    logic        ld;
    logic        st;
    logic        br;
    logic        mul;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic valid;
    logic stall;
    dec_t rec;
  } cyc_t;

  cyc_t expQ[$];
  int   checks = 0;
  int   fails = 0;

  logic mValid = 1'b0;
  dec_t mRec = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned fieldOf(input logic [31:0] w, input int lo, input int bits);
    return (int'(w) >>> lo) & ((1 << bits) - 1);
  endfunction

  function automatic logic [31:0] sext(input int unsigned v, input int bits);
    int unsigned m;
    m = v & ((32'd1 << bits) - 1);
    if (((m >> (bits - 1)) & 1) == 1) m = m - (32'd1 << bits);
    return m;
  endfunction

  // Reference decode straight from the instruction-set field definitions.
  function automatic dec_t refDecode(input logic [31:0] ir, input logic [31:0] pc);
    dec_t d;
    int unsigned opc, f7, v;
    bit known;
    d = '0;
    d.pc = pc;
    d.ir = ir;
    opc = fieldOf(ir, 2, 5);
    f7 = fieldOf(ir, 25, 7);
    case (opc)
      0, 4, 25, 28: d.imm = sext(fieldOf(ir, 20, 12), 12);
      8: d.imm = sext(fieldOf(ir, 25, 7) * 32 + fieldOf(ir, 7, 5), 12);
      24: begin
        v = fieldOf(ir, 31, 1) * 4096 + fieldOf(ir, 7, 1) * 2048 +
            fieldOf(ir, 25, 6) * 32 + fieldOf(ir, 8, 4) * 2;
        d.imm = sext(v, 13);
      end
      13, 5: d.imm = ir & 32'hFFFFF000;
      27: begin
        v = fieldOf(ir, 31, 1) * 1048576 + fieldOf(ir, 12, 8) * 4096 +
            fieldOf(ir, 20, 1) * 2048 + fieldOf(ir, 21, 10) * 2;
        d.imm = sext(v, 21);
      end
      default: d.imm = 32'd0;
    endcase
    d.ld = (opc == 0);
    d.st = (opc == 8);
    d.br = (opc == 24);
    known = opc inside {13, 5, 27, 25, 24, 0, 8, 4, 12, 28, 3};
    d.ill = (fieldOf(ir, 0, 2) != 3) || !known;
    if (opc == 12) begin
`ifdef URV_DECODE_MUL_EN
      d.mul = (f7 == 1);
      if (f7 != 0 && f7 != 32 && f7 != 1) d.ill = 1'b1;
`else
      if (f7 != 0 && f7 != 32) d.ill = 1'b1;
`endif
    end
    return d;
  endfunction

  // One pipeline cycle: drive inputs, queue the expectation for this cycle, advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                               input logic st, input logic kl);
    cyc_t e;
    int unsigned opc, heldRd;
    bit uses1, uses2, haz;
    @(posedge clk_i);
    #2;
    f_valid_i = v;
    f_ir_i = ir;
    f_pc_i = pc;
    x_stall_i = st;
    x_kill_i = kl;
    opc = fieldOf(ir, 2, 5);
    heldRd = fieldOf(mRec.ir, 7, 5);
    uses1 = !(opc inside {13, 5, 27});
    uses2 = opc inside {12, 8, 24};
    haz = v && mValid && mRec.ld && heldRd != 0 &&
          ((uses1 && fieldOf(ir, 15, 5) == heldRd) || (uses2 && fieldOf(ir, 20, 5) == heldRd));
    e.valid = mValid;
    e.stall = st || (haz && !kl);
    e.rec = mRec;
    expQ.push_back(e);
    if (kl) mValid = 1'b0;
    else if (st) mValid = mValid;
    else if (haz) mValid = 1'b0;
    else begin
      mValid = v;
      mRec = refDecode(ir, pc);
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] opcTab [13];
    logic [6:0] f7;
    logic [1:0] low;
    opcTab = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100, 5'b01101,
               5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b11111, 5'b01011};
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    low = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), opcTab[$urandom_range(0, 12)], low};
  endfunction

  initial begin
    cyc_t e;
    forever begin
      @(negedge clk_i);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("d_valid_o", d_valid_o, e.valid);
        checkOutput("d_stall_o", d_stall_o, e.stall);
        if (e.valid) begin
          checkOutput("d_pc_o", d_pc_o, e.rec.pc);
          checkOutput("d_ir_o", d_ir_o, e.rec.ir);
          checkOutput("d_opcode_o", d_opcode_o, fieldOf(e.rec.ir, 2, 5));
          checkOutput("d_fun_o", d_fun_o, fieldOf(e.rec.ir, 12, 3));
          checkOutput("d_rs1_o", d_rs1_o, fieldOf(e.rec.ir, 15, 5));
          checkOutput("d_rs2_o", d_rs2_o, fieldOf(e.rec.ir, 20, 5));
          checkOutput("d_rd_o", d_rd_o, fieldOf(e.rec.ir, 7, 5));
          checkOutput("d_imm_o", d_imm_o, e.rec.imm);
          checkOutput("d_is_load_o", d_is_load_o, e.rec.ld);
          checkOutput("d_is_store_o", d_is_store_o, e.rec.st);
          checkOutput("d_is_branch_o", d_is_branch_o, e.rec.br);
          checkOutput("d_is_mul_o", d_is_mul_o, e.rec.mul);
          checkOutput("d_illegal_o", d_illegal_o, e.rec.ill);
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " d_valid_o"}, d_valid_o, 0);
    checkOutput({tag, " d_pc_o"}, d_pc_o, 0);
    checkOutput({tag, " d_ir_o"}, d_ir_o, 0);
    checkOutput({tag, " d_rd_o"}, d_rd_o, 0);
    checkOutput({tag, " d_imm_o"}, d_imm_o, 0);
    checkOutput({tag, " flags"}, {d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o}, 0);
  endtask

  initial begin
    $display("[TB] start");
    #1;
    checkAllZero("reset");
    #21 rst_n_i = 1'b1;

    // ADDI x1,x0,5 at 0x100
    applyStimulus(1, 32'h00500093, 32'h100, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("addi valid", d_valid_o, 1);
    checkOutput("addi pc", d_pc_o, 32'h100);
    checkOutput("addi rd", d_rd_o, 1);
    checkOutput("addi imm", d_imm_o, 5);
    checkOutput("addi illegal", d_illegal_o, 0);

    // LW x5,0(x2) then dependent ADD x6,x5,x1
    applyStimulus(1, 32'h00012283, 32'h104, 0, 0);
    applyStimulus(1, 32'h00128333, 32'h108, 0, 0);
    #1 checkOutput("hazard stall", d_stall_o, 1);
    applyStimulus(1, 32'h00128333, 32'h108, 0, 0);
    #1;
    checkOutput("bubble valid", d_valid_o, 0);
    checkOutput("bubble stall", d_stall_o, 0);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("add valid", d_valid_o, 1);
    checkOutput("add rs1", d_rs1_o, 5);

    // LW x0 then ADD reading x0: no hazard
    applyStimulus(1, 32'h00012003, 32'h10C, 0, 0);
    applyStimulus(1, 32'h00100333, 32'h110, 0, 0);
    #1 checkOutput("x0 no stall", d_stall_o, 0);
    applyStimulus(0, 0, 0, 0, 0);
    #1 checkOutput("x0 add valid", d_valid_o, 1);

    // BEQ offset -4, then kill while execute stalls
    applyStimulus(1, 32'hFE000EE3, 32'h114, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    #1;
    checkOutput("beq imm", d_imm_o, 32'hFFFFFFFC);
    checkOutput("beq branch", d_is_branch_o, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #1 checkOutput("kill valid", d_valid_o, 0);

    // MUL x3,x1,x2
    applyStimulus(1, 32'h022081B3, 32'h118, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
`ifdef URV_DECODE_MUL_EN
    checkOutput("mul is_mul", d_is_mul_o, 1);
    checkOutput("mul illegal", d_illegal_o, 0);
`else
    checkOutput("mul is_mul", d_is_mul_o, 0);
    checkOutput("mul illegal", d_illegal_o, 1);
`endif

    // Hold for 3 stalled cycles with a changing fetch word, then reset mid-stall
    applyStimulus(1, 32'h00A00113, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, randInstr(), 32'h300 + 4 * i, 1, 0);
    #4;
    rst_n_i = 1'b0;
    #1 checkAllZero("async reset");
    @(posedge clk_i);
    #2;
    f_valid_i = 1'b0;
    x_stall_i = 1'b0;
    mValid = 1'b0;
    mRec = '0;
    rst_n_i = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) < 8, randInstr(), $urandom & 32'hFFFFFFFC,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk_i);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
